// File: rtl/sys_cntr_mc.sv
// Multi-channel up/down counter with per-channel wrap/saturate mode, step and [min,max] window.
// Optional macro SYS_CNTR_EVT_EN adds a registered per-channel boundary event output.
module sys_cntr_mc #(
    parameter int CH     = 4,
    parameter int W      = 8,
    parameter int STEP_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH-1:0]        i_clr,
    input  logic [CH-1:0]        i_ld,
    input  logic [CH*W-1:0]      i_ld_val,
    input  logic [CH-1:0]        i_en,
    input  logic [CH-1:0]        i_dir,
    input  logic [CH-1:0]        i_mode,
    input  logic [CH*STEP_W-1:0] i_step,
    input  logic [CH*W-1:0]      i_min,
    input  logic [CH*W-1:0]      i_max,
    output logic [CH*W-1:0]      o_cnt,
    output logic [CH-1:0]        o_at_min,
    output logic [CH-1:0]        o_at_max,
    output logic [CH-1:0]        o_evt
);

    // Arithmetic width wide enough that neither cnt+step nor min+step can overflow.
    localparam int AW = ((W > STEP_W) ? W : STEP_W) + 1;

    function automatic logic [W-1:0] clamp_val(
        input logic [W-1:0] v,
        input logic [W-1:0] lo,
        input logic [W-1:0] hi
    );
        logic [W-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0]      cnt_r;
        logic [W-1:0]      cnt_nxt_s;
        logic [W-1:0]      min_s;
        logic [W-1:0]      max_s;
        logic [STEP_W-1:0] step_s;
        logic [AW-1:0]     cnt_x_s;
        logic [AW-1:0]     step_x_s;
        logic [AW-1:0]     min_x_s;
        logic [AW-1:0]     max_x_s;
        logic [AW-1:0]     sum_s;
        logic [AW-1:0]     diff_s;
        logic [AW-1:0]     lim_s;
        logic              cfg_err_s;
        logic              bnd_s;

        assign min_s     = i_min[c*W +: W];
        assign max_s     = i_max[c*W +: W];
        assign step_s    = i_step[c*STEP_W +: STEP_W];
        assign cnt_x_s   = {{(AW-W){1'b0}}, cnt_r};
        assign step_x_s  = {{(AW-STEP_W){1'b0}}, step_s};
        assign min_x_s   = {{(AW-W){1'b0}}, min_s};
        assign max_x_s   = {{(AW-W){1'b0}}, max_s};
        assign sum_s     = cnt_x_s + step_x_s;
        assign diff_s    = cnt_x_s - step_x_s;
        assign lim_s     = min_x_s + step_x_s;
        assign cfg_err_s = (min_s > max_s);

        // Next-state selection: clear > load > enabled step; boundary flag only on the step path.
        always_comb begin
            cnt_nxt_s = cnt_r;
            bnd_s     = 1'b0;
            if (i_clr[c]) begin
                cnt_nxt_s = min_s;
            end else if (i_ld[c]) begin
                cnt_nxt_s = clamp_val(i_ld_val[c*W +: W], min_s, max_s);
            end else if (i_en[c] && !cfg_err_s && (step_s != {STEP_W{1'b0}})) begin
                if (i_dir[c]) begin
                    if (sum_s <= max_x_s) begin
                        cnt_nxt_s = sum_s[W-1:0];
                    end else begin
                        bnd_s     = 1'b1;
                        cnt_nxt_s = i_mode[c] ? max_s : min_s;
                    end
                end else begin
                    if (cnt_x_s < lim_s) begin
                        bnd_s     = 1'b1;
                        cnt_nxt_s = i_mode[c] ? min_s : max_s;
                    end else begin
                        cnt_nxt_s = diff_s[W-1:0];
                    end
                end
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end

        // Counter register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= {W{1'b0}};
            end else begin
                cnt_r <= cnt_nxt_s;
            end
        end

        assign o_cnt[c*W +: W] = cnt_r;
        assign o_at_min[c]     = (cnt_r == min_s);
        assign o_at_max[c]     = (cnt_r == max_s);

`ifdef SYS_CNTR_EVT_EN
        logic evt_r;

        // Boundary event, high for the cycle after a wrap/clip edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                evt_r <= 1'b0;
            end else begin
                evt_r <= bnd_s;
            end
        end

        assign o_evt[c] = evt_r;
`else
        assign o_evt[c] = 1'b0 & bnd_s;
`endif
    end

endmodule

// File: tb/tb_sys_cntr_mc.sv
// Directed self-checking bench for sys_cntr_mc (CH=4, W=8, STEP_W=4).
module tb_sys_cntr_mc;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = 4;
`ifdef SYS_CNTR_EVT_EN
    localparam logic EVT_ON = 1'b1;
`else
    localparam logic EVT_ON = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   i_clr, i_ld, i_en, i_dir, i_mode;
    logic [CH*W-1:0] i_ld_val, i_min, i_max;
    logic [CH*SW-1:0] i_step;
    logic [CH*W-1:0] o_cnt;
    logic [CH-1:0]   o_at_min, o_at_max, o_evt;

    int checks   = 0;
    int failures = 0;

    sys_cntr_mc #(.CH(CH), .W(W), .STEP_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_clr(i_clr), .i_ld(i_ld), .i_ld_val(i_ld_val), .i_en(i_en),
        .i_dir(i_dir), .i_mode(i_mode), .i_step(i_step),
        .i_min(i_min), .i_max(i_max),
        .o_cnt(o_cnt), .o_at_min(o_at_min), .o_at_max(o_at_max), .o_evt(o_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int c, input logic [7:0] mn, input logic [7:0] mx,
                       input logic [3:0] st, input logic up, input logic sat);
        i_min[c*W +: W]    = mn;
        i_max[c*W +: W]    = mx;
        i_step[c*SW +: SW] = st;
        i_dir[c]           = up;
        i_mode[c]          = sat;
    endtask

    function automatic logic [7:0] cnt(input int c);
        return o_cnt[c*W +: W];
    endfunction

    initial begin
        rst_n = 1'b1;
        i_clr = '0; i_ld = '0; i_en = '0; i_dir = '0; i_mode = '0;
        i_ld_val = '0; i_min = '0; i_max = '0; i_step = '0;
        #1 rst_n = 1'b0;
        #20;
        check_val("rst_cnt", o_cnt, 32'h0);
        check_val("rst_evt", {28'h0, o_evt}, 32'h0);
        check_val("rst_at_min", {28'h0, o_at_min}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // wrap up on ch0: 2 -> 5, 8, 2 (evt), 5
        cfg(0, 8'd2, 8'd9, 4'd3, 1'b1, 1'b0);
        i_clr[0] = 1'b1; tick(); i_clr[0] = 1'b0;
        check_val("wrap_clr", cnt(0), 32'd2);
        i_en[0] = 1'b1;
        tick(); check_val("wrap_e1", cnt(0), 32'd5); check_val("wrap_e1_evt", o_evt[0], 32'd0);
        tick(); check_val("wrap_e2", cnt(0), 32'd8); check_val("wrap_e2_evt", o_evt[0], 32'd0);
        tick(); check_val("wrap_e3", cnt(0), 32'd2); check_val("wrap_e3_evt", o_evt[0], {31'd0, EVT_ON});
        tick(); check_val("wrap_e4", cnt(0), 32'd5); check_val("wrap_e4_evt", o_evt[0], 32'd0);
        i_en[0] = 1'b0;

        // saturate down on ch1: 12 -> 7, 4 (evt), 4 (evt)
        cfg(1, 8'd4, 8'd200, 4'd5, 1'b0, 1'b1);
        i_ld_val[1*W +: W] = 8'd12; i_ld[1] = 1'b1; tick(); i_ld[1] = 1'b0;
        check_val("sat_ld", cnt(1), 32'd12);
        i_en[1] = 1'b1;
        tick(); check_val("sat_e1", cnt(1), 32'd7); check_val("sat_e1_evt", o_evt[1], 32'd0);
        tick(); check_val("sat_e2", cnt(1), 32'd4); check_val("sat_e2_evt", o_evt[1], {31'd0, EVT_ON});
        tick(); check_val("sat_e3", cnt(1), 32'd4); check_val("sat_e3_evt", o_evt[1], {31'd0, EVT_ON});
        check_val("sat_at_min", o_at_min[1], 32'd1);
        check_val("sat_at_max", o_at_max[1], 32'd0);
        i_en[1] = 1'b0;

        // priority and load clamping on ch2
        cfg(2, 8'd10, 8'd200, 4'd1, 1'b1, 1'b0);
        i_ld_val[2*W +: W] = 8'd50;
        i_clr[2] = 1'b1; i_ld[2] = 1'b1; i_en[2] = 1'b1;
        tick(); check_val("prio_clr", cnt(2), 32'd10); check_val("prio_clr_evt", o_evt[2], 32'd0);
        i_clr[2] = 1'b0; i_ld_val[2*W +: W] = 8'd250;
        tick(); check_val("ld_clip_hi", cnt(2), 32'd200); check_val("ld_at_max", o_at_max[2], 32'd1);
        i_ld_val[2*W +: W] = 8'd3;
        tick(); check_val("ld_clip_lo", cnt(2), 32'd10);
        i_ld[2] = 1'b0; i_en[2] = 1'b0;

        // full-range overflow on ch3: 250 + 15 wraps to 0
        cfg(3, 8'd0, 8'd255, 4'd15, 1'b1, 1'b0);
        i_ld_val[3*W +: W] = 8'd250; i_ld[3] = 1'b1; tick(); i_ld[3] = 1'b0;
        check_val("ovf_ld", cnt(3), 32'd250);
        i_en[3] = 1'b1;
        tick(); check_val("ovf_wrap", cnt(3), 32'd0); check_val("ovf_evt", o_evt[3], {31'd0, EVT_ON});
        check_val("ovf_at_min", o_at_min[3], 32'd1);
        i_en[3] = 1'b0;

        // ch0 config error holds; ch1 counts normally alongside
        cfg(0, 8'd9, 8'd3, 4'd1, 1'b1, 1'b0);
        cfg(1, 8'd0, 8'd100, 4'd2, 1'b1, 1'b0);
        i_en[0] = 1'b1; i_en[1] = 1'b1;
        tick(); check_val("err_hold1", cnt(0), 32'd5); check_val("ind_c1_1", cnt(1), 32'd6);
        check_val("err_evt", o_evt[0], 32'd0);
        tick(); check_val("err_hold2", cnt(0), 32'd5); check_val("ind_c1_2", cnt(1), 32'd8);
        i_en[0] = 1'b0;
        i_step[1*SW +: SW] = 4'd0;
        tick(); check_val("step0_hold", cnt(1), 32'd8); check_val("step0_evt", o_evt[1], 32'd0);
        // counter above a shrunk window counting up clips to max
        cfg(1, 8'd0, 8'd5, 4'd1, 1'b1, 1'b1);
        tick(); check_val("oow_clip", cnt(1), 32'd5); check_val("oow_evt", o_evt[1], {31'd0, EVT_ON});
        i_en[1] = 1'b0;
        tick(); check_val("idle_hold", cnt(1), 32'd5); check_val("idle_evt", o_evt[1], 32'd0);

        // async reset mid-count at 0x37, then normal counting resumes
        cfg(2, 8'd0, 8'd255, 4'd1, 1'b1, 1'b0);
        i_ld_val[2*W +: W] = 8'h36; i_ld[2] = 1'b1; tick(); i_ld[2] = 1'b0;
        i_en[2] = 1'b1;
        tick(); check_val("pre_rst", cnt(2), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_cnt", o_cnt, 32'h0);
        check_val("async_rst_evt", {28'h0, o_evt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check_val("post_rst", cnt(2), 32'd1);
        i_en[2] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
